// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the load-formatting slice of the core.
package riscv_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [6:0] OPC_LOAD = 7'b0000011;

   // Values are the RV32I funct3 encodings, so they are pinned explicitly.
   typedef enum logic [2:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LBU = 3'b100,
      LHU = 3'b101
   } l_func;

endpackage

// File: rtl/instr_io.sv
// Instruction/data datapath bundle shared by the execute slices of the core.
interface Instr_IO;
   import riscv_pkg::*;

   logic [XLEN-1:0] idata;
   logic [XLEN-1:0] drdata;
   logic [XLEN-1:0] daddr;
   logic [XLEN-1:0] iaddr;
   logic [XLEN-1:0] imm;
   logic [XLEN-1:0] rv1;
   logic [XLEN-1:0] rv2;
   logic [XLEN-1:0] regdata_L;
   logic            load_fault;
   logic [XLEN-1:0] fault_pc;

   modport L_type_io_ports (
      input  idata, drdata, daddr, iaddr, imm, rv1, rv2,
      output regdata_L, load_fault, fault_pc
   );

endinterface

// File: rtl/l_extract.sv
// Combinational load lane select and extension, plus misaligned/illegal flags.
module l_extract
   import riscv_pkg::*;
(
   input  logic [XLEN-1:0] drdata,
   input  logic [1:0]      addr_lo,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] data,
   output logic            misaligned,
   output logic            illegal
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Misaligned accesses keep the lane picked by the upper address bits; no rotation.
   assign byte_sel = drdata[{addr_lo, 3'b000} +: 8];
   assign half_sel = addr_lo[1] ? drdata[31:16] : drdata[15:0];

   always_comb begin
      data       = '0;
      misaligned = 1'b0;
      illegal    = 1'b0;
      case (funct3)
         LB:  data = {{24{byte_sel[7]}}, byte_sel};
         LH: begin
            data       = {{16{half_sel[15]}}, half_sel};
            misaligned = addr_lo[0];
         end
         LW: begin
            data       = drdata;
            misaligned = |addr_lo;
         end
         LBU: data = {24'd0, byte_sel};
         LHU: begin
            data       = {16'd0, half_sel};
            misaligned = addr_lo[0];
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/l_type.sv
// RV32I load-result formatter with a registered fault status for bad loads.
module l_type
   import riscv_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   Instr_IO.L_type_io_ports      io
);

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [XLEN-1:0] ext_data;
   logic            misaligned;
   logic            illegal;

   logic            load_fault_d, load_fault_q;
   logic [XLEN-1:0] fault_pc_d, fault_pc_q;

   logic            unused_sig;

   assign opcode = io.idata[6:0];
   assign funct3 = io.idata[14:12];

   l_extract u_extract (
      .drdata     (io.drdata),
      .addr_lo    (io.daddr[1:0]),
      .funct3     (funct3),
      .data       (ext_data),
      .misaligned (misaligned),
      .illegal    (illegal)
   );

   // Result is opcode-independent; writeback enable is gated downstream.
   assign io.regdata_L = ext_data;

   always_comb begin
      load_fault_d = (opcode == OPC_LOAD) && (misaligned || illegal);
      fault_pc_d   = load_fault_d ? io.iaddr : fault_pc_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         load_fault_q <= 1'b0;
         fault_pc_q   <= '0;
      end else begin
         load_fault_q <= load_fault_d;
         fault_pc_q   <= fault_pc_d;
      end
   end

   assign io.load_fault = load_fault_q;
   assign io.fault_pc   = fault_pc_q;

   assign unused_sig = ^{io.idata[31:15], io.idata[11:7], io.daddr[31:2],
                         io.imm, io.rv1, io.rv2};

endmodule

// File: tb/tb_l_type.sv
// Directed checks of load formatting and fault capture for l_type.
module tb_l_type;
   import riscv_pkg::*;

   localparam logic [6:0] OPC_ALU = 7'b0010011;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   Instr_IO io ();

   l_type dut (
      .clk   (clk),
      .reset (rst_n),
      .io    (io)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, act, exp);
      end
   endtask

   task automatic drive(input logic [2:0] f3, input logic [6:0] opc,
                        input logic [31:0] addr, input logic [31:0] rd,
                        input logic [31:0] pc);
      io.idata  = {17'd0, f3, 5'd0, opc};
      io.daddr  = addr;
      io.drdata = rd;
      io.iaddr  = pc;
      #1;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   logic [31:0] lb_exp [4];

   initial begin
      n_tests = 0;
      n_fail  = 0;
      io.imm  = 32'h0;
      io.rv1  = 32'h0;
      io.rv2  = 32'h0;
      rst_n   = 1'b0;
      drive(3'b000, OPC_LOAD, 32'h0, 32'h0, 32'h0);
      chk("rst_fault", {31'd0, io.load_fault}, 32'd0);
      chk("rst_pc", io.fault_pc, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Common stimulus: drdata F1F2F3F4, daddr 00100002
      @(negedge clk);
      drive(LB, OPC_LOAD, 32'h00100002, 32'hF1F2F3F4, 32'h10);
      chk("lb", io.regdata_L, 32'hFFFFFFF2);
      step();
      chk("lb_nofault", {31'd0, io.load_fault}, 32'd0);

      @(negedge clk);
      drive(LH, OPC_LOAD, 32'h00100002, 32'hF1F2F3F4, 32'h14);
      chk("lh", io.regdata_L, 32'hFFFFF1F2);
      step();
      chk("lh_nofault", {31'd0, io.load_fault}, 32'd0);

      @(negedge clk);
      drive(LW, OPC_LOAD, 32'h00100002, 32'hF1F2F3F4, 32'h20);
      chk("lw", io.regdata_L, 32'hF1F2F3F4);
      step();
      chk("lw_fault", {31'd0, io.load_fault}, 32'd1);
      chk("lw_pc", io.fault_pc, 32'h20);

      @(negedge clk);
      drive(LBU, OPC_LOAD, 32'h00100002, 32'hF1F2F3F4, 32'h24);
      chk("lbu", io.regdata_L, 32'h000000F2);
      step();
      chk("lbu_nofault", {31'd0, io.load_fault}, 32'd0);
      chk("pc_hold", io.fault_pc, 32'h20);

      @(negedge clk);
      drive(LHU, OPC_LOAD, 32'h00100002, 32'hF1F2F3F4, 32'h28);
      chk("lhu", io.regdata_L, 32'h0000F1F2);
      step();
      chk("lhu_nofault", {31'd0, io.load_fault}, 32'd0);

      // Byte lanes at every offset
      lb_exp[0] = 32'h0000004F;
      lb_exp[1] = 32'h0000003F;
      lb_exp[2] = 32'h0000002F;
      lb_exp[3] = 32'h0000001F;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive(LB, OPC_LOAD, 32'(i), 32'h1F2F3F4F, 32'h30);
         chk($sformatf("lb_off%0d", i), io.regdata_L, lb_exp[i]);
      end
      step();
      chk("lb_off_nofault", {31'd0, io.load_fault}, 32'd0);

      // Misaligned halfword still returns the low half, no rotation
      @(negedge clk);
      drive(LH, OPC_LOAD, 32'h00000001, 32'h1F2F3F4F, 32'h40);
      chk("lh_mis_data", io.regdata_L, 32'h00003F4F);
      step();
      chk("lh_mis_fault", {31'd0, io.load_fault}, 32'd1);
      chk("lh_mis_pc", io.fault_pc, 32'h40);

      @(negedge clk);
      drive(3'b011, OPC_LOAD, 32'h0, 32'hFFFFFFFF, 32'h44);
      chk("f011_data", io.regdata_L, 32'h0);
      step();
      chk("f011_fault", {31'd0, io.load_fault}, 32'd1);
      chk("f011_pc", io.fault_pc, 32'h44);

      @(negedge clk);
      drive(3'b011, OPC_ALU, 32'h0, 32'hFFFFFFFF, 32'h48);
      chk("nonload_data", io.regdata_L, 32'h0);
      step();
      chk("nonload_fault", {31'd0, io.load_fault}, 32'd0);
      chk("nonload_pc", io.fault_pc, 32'h44);

      @(negedge clk);
      drive(LW, OPC_ALU, 32'h00000003, 32'h12345678, 32'h4C);
      chk("lw_nonload_data", io.regdata_L, 32'h12345678);
      step();
      chk("lw_nonload_fault", {31'd0, io.load_fault}, 32'd0);

      @(negedge clk);
      drive(3'b110, OPC_LOAD, 32'h0, 32'hFFFFFFFF, 32'h50);
      chk("f110_data", io.regdata_L, 32'h0);
      drive(3'b111, OPC_LOAD, 32'h0, 32'hFFFFFFFF, 32'h54);
      chk("f111_data", io.regdata_L, 32'h0);
      drive(LHU, OPC_LOAD, 32'h00000003, 32'h8001C0DE, 32'h58);
      chk("lhu_mis_data", io.regdata_L, 32'h00008001);
      step();
      chk("lhu_mis_fault", {31'd0, io.load_fault}, 32'd1);
      chk("lhu_mis_pc", io.fault_pc, 32'h58);

      // Reset asserted between edges clears the fault immediately
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_fault", {31'd0, io.load_fault}, 32'd0);
      chk("async_rst_pc", io.fault_pc, 32'd0);
      chk("async_rst_data", io.regdata_L, 32'h00008001);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
